// File: rtl/mixcol_seq.sv
// Steps a shared combinational MixColumns column unit across a 128-bit AES state,
// one column per cycle, with a final-round bypass straight to the output stage.
module mixcol_seq #(
    parameter int COL_W   = 32,
    parameter int NUM_COL = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    input  logic [COL_W*NUM_COL-1:0]   state_in,
    output logic                       col_valid_o,
    output logic [$clog2(NUM_COL)-1:0] col_idx_o,
    output logic [COL_W-1:0]           col_data_o,
    input  logic [COL_W-1:0]           col_result_i,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COL_W*NUM_COL-1:0]   state_out,
    output logic                       busy
);

    // state | meaning
    // IDLE  | waiting for a state; in_ready high
    // RUN   | one column through the column unit per cycle
    // DONE  | result presented on state_out until out_ready

    localparam int STATE_W = COL_W * NUM_COL;
    localparam int CNT_W   = $clog2(NUM_COL);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NUM_COL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } fsm_t;

    fsm_t               fsm_q;
    fsm_t               fsm_d;
    logic [CNT_W-1:0]   col_cnt;
    logic [STATE_W-1:0] state_reg;
    int                 slot_hi;

    // Column 0 lives in the most significant word.
    assign slot_hi = STATE_W - 1 - COL_W * int'(col_cnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q     <= S_IDLE;
            col_cnt   <= '0;
            state_reg <= '0;
        end else begin
            fsm_q <= fsm_d;
            case (fsm_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_reg <= state_in;
                        col_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    state_reg[slot_hi -: COL_W] <= col_result_i;
                    col_cnt <= (col_cnt == LAST_COL) ? '0 : col_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        in_ready    = 1'b0;
        col_valid_o = 1'b0;
        col_idx_o   = '0;
        col_data_o  = '0;
        out_valid   = 1'b0;
        state_out   = '0;
        busy        = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                // Held low while reset is asserted so nothing is accepted then.
                in_ready = rst_n;
                if (in_valid) begin
                    fsm_d = in_last ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy        = 1'b1;
                col_valid_o = 1'b1;
                col_idx_o   = col_cnt;
                col_data_o  = state_reg[slot_hi -: COL_W];
                if (col_cnt == LAST_COL) begin
                    fsm_d = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                state_out = state_reg;
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mixcol_seq.sv
// Scoreboard bench for mixcol_seq: a stimulus process queues expected results,
// a negedge monitor checks columns, latency and output states.
module tb_mixcol_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_last = 1'b0;
    logic [127:0] state_in = '0;
    logic         col_valid_o;
    logic [1:0]   col_idx_o;
    logic [31:0]  col_data_o;
    logic [31:0]  col_result_i;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] state_out;
    logic         busy;

    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    bit           col_inv = 1'b0;
    logic [127:0] exp_q[$];
    int           lat_q[$];

    mixcol_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_last      (in_last),
        .state_in     (state_in),
        .col_valid_o  (col_valid_o),
        .col_idx_o    (col_idx_o),
        .col_data_o   (col_data_o),
        .col_result_i (col_result_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .state_out    (state_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] colfn(input logic [31:0] c, input bit inv);
        logic [7:0] a0, a1, a2, a3;
        if (inv) return ~c;
        a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    assign col_result_i = colfn(col_data_o, col_inv);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Monitor: reference column model, latency and output scoreboard
    logic [127:0] m_state;
    int           m_left = 0;
    int           m_idx = 0;
    bit           prev_ov = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_left  = 0;
            m_idx   = 0;
            prev_ov = 1'b0;
        end else begin
            if (m_left > 0) begin
                chk("col_valid_run", col_valid_o, 1);
                chk("col_idx", col_idx_o, m_idx);
                chk("col_data", col_data_o, m_state[127 - 32*m_idx -: 32]);
                m_state[127 - 32*m_idx -: 32] = colfn(m_state[127 - 32*m_idx -: 32], col_inv);
                m_idx++;
                m_left--;
            end else begin
                chk("col_valid_idle", col_valid_o, 0);
                chk("col_data_idle", col_data_o, 0);
            end
            if (out_valid && !prev_ov) begin
                if (lat_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL out_unexpected: out_valid at cycle %0d with nothing pending", cyc);
                end else begin
                    chk("latency", cyc, lat_q.pop_front());
                end
            end
            prev_ov = out_valid;
            if (!out_valid) chk("state_out_idle", state_out, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL out_extra: state_out %h with empty scoreboard", state_out);
                end else begin
                    chk("state_out", state_out, exp_q.pop_front());
                    chk("model_state", state_out, m_state);
                end
            end
            if (in_valid && in_ready) begin
                m_state = state_in;
                m_idx   = 0;
                m_left  = in_last ? 0 : 4;
            end
        end
    end

    // Drive one state and hold until accepted; returns the handshake cycle.
    task automatic send(input logic [127:0] d, input logic last, input logic [127:0] e, output int acc);
        bit ok = 1'b0;
        state_in = d;
        in_last  = last;
        in_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                lat_q.push_back(cyc + (last ? 1 : 5));
                acc = cyc;
                ok  = 1'b1;
                break;
            end
        end
        if (!ok) timeout("send");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) timeout(name);
    endtask

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] ORD_IN   = 128'h01234567_89abcdef_fedcba98_76543210;
    localparam logic [127:0] ORD_OUT  = 128'hfedcba98_76543210_01234567_89abcdef;
    localparam logic [127:0] B2B_A    = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] B2B_AX   = 128'hffeeddcc_bbaa9988_77665544_33221100;
    localparam logic [127:0] B2B_B    = 128'h00000000_00000000_00000000_00000000;
    localparam logic [127:0] B2B_BX   = 128'hffffffff_ffffffff_ffffffff_ffffffff;
    localparam logic [127:0] B2B_C    = 128'hdeadbeef_00000000_ffffffff_12345678;
    localparam logic [127:0] B2B_CX   = 128'h21524110_ffffffff_00000000_edcba987;

    initial begin
        int a0, a1, a2;
        bit ok;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_col_valid", col_valid_o, 0);
        chk("rst_col_idx", col_idx_o, 0);
        chk("rst_state_out", state_out, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // FIPS-197 MixColumns vector
        send(FIPS_IN, 1'b0, FIPS_OUT, a0);
        in_valid = 1'b0;
        chk("busy_run", busy, 1);
        wait_idle("fips");

        // Final-round bypass
        send(FIPS_IN, 1'b1, FIPS_IN, a0);
        in_valid = 1'b0;
        chk("bypass_out_valid", out_valid, 1);
        wait_idle("bypass");

        // Column order with an inverting column unit
        col_inv = 1'b1;
        send(ORD_IN, 1'b0, ORD_OUT, a0);
        in_valid = 1'b0;
        wait_idle("order");

        // Backpressure in DONE
        col_inv   = 1'b0;
        out_ready = 1'b0;
        send(FIPS_IN, 1'b0, FIPS_OUT, a0);
        in_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("bp_wait");
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            state_in = {4{$urandom()}};
            in_last  = (i % 3 == 0);
            @(posedge clk);
            #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_state_out", state_out, FIPS_OUT);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle("bp_release");
        chk("bp_idle_busy", busy, 0);

        // Reset in the middle of a run
        send(FIPS_IN, 1'b0, FIPS_OUT, a0);
        in_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (col_valid_o && col_idx_o == 2'd2) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("midop_wait");
        rst_n = 1'b0;
        exp_q.delete();
        lat_q.delete();
        @(posedge clk);
        #1;
        chk("midop_out_valid", out_valid, 0);
        chk("midop_col_valid", col_valid_o, 0);
        chk("midop_col_idx", col_idx_o, 0);
        chk("midop_col_data", col_data_o, 0);
        chk("midop_state_out", state_out, 0);
        chk("midop_busy", busy, 0);
        chk("midop_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("midop_in_ready_rel", in_ready, 1);
        send(FIPS_IN, 1'b0, FIPS_OUT, a0);
        in_valid = 1'b0;
        wait_idle("midop_after");

        // Back-to-back with in_valid held high
        col_inv = 1'b1;
        send(B2B_A, 1'b0, B2B_AX, a0);
        send(B2B_B, 1'b0, B2B_BX, a1);
        send(B2B_C, 1'b0, B2B_CX, a2);
        in_valid = 1'b0;
        chk("b2b_spacing_1", a1 - a0, 6);
        chk("b2b_spacing_2", a2 - a1, 6);
        wait_idle("b2b");
        repeat (2) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
